// File: rtl/shift_left2_if.sv
// Port bundle for the branch-offset scaler: immediate/PC inputs,
// pipeline controls, and the combinational plus EX/MEM registered results.
interface shift_left2_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] extdimm;
  logic [WIDTH-1:0] pc_plus4;
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] extdimmt4;
  logic             shift_ovf;
  logic [WIDTH-1:0] extdimmt4_q;
  logic [WIDTH-1:0] target_q;
  logic             out_valid;

  // Producer side: the decode stage driving the scaler and observing results.
  modport master (
    output extdimm,
    output pc_plus4,
    output in_valid,
    output stall,
    output flush,
    input  extdimmt4,
    input  shift_ovf,
    input  extdimmt4_q,
    input  target_q,
    input  out_valid
  );

  // Scaler side.
  modport slave (
    input  extdimm,
    input  pc_plus4,
    input  in_valid,
    input  stall,
    input  flush,
    output extdimmt4,
    output shift_ovf,
    output extdimmt4_q,
    output target_q,
    output out_valid
  );
endinterface

// File: rtl/shift_left2.sv
// Branch-offset scaler: turns a sign-extended word offset into a byte offset
// and registers it together with the branch target for the EX/MEM boundary.
module shift_left2 #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 2
) (
  input logic         clk,
  input logic         reset,
  shift_left2_if.slave bus
);

  // The shift alters the signed value unless the top SHIFT+1 bits all match.
  function automatic logic sign_bits_differ(input logic [WIDTH-1:0] value);
    logic [SHIFT:0] top_s;
    top_s = value[WIDTH-1 -: SHIFT+1];
    return !((top_s == '0) || (top_s == '1));
  endfunction

  logic [WIDTH-1:0] extdimmt4_s;
  logic             shift_ovf_s;
  logic [WIDTH-1:0] target_sum_s;

  logic [WIDTH-1:0] extdimmt4_r;
  logic [WIDTH-1:0] target_r;
  logic             out_valid_r;

  // Zero-latency scaling, overflow flag and modulo-2^WIDTH branch sum.
  always_comb begin
    extdimmt4_s  = bus.extdimm << SHIFT;
    shift_ovf_s  = sign_bits_differ(bus.extdimm);
    target_sum_s = bus.pc_plus4 + extdimmt4_s;
  end

  // EX/MEM register: reset beats flush, flush beats stall; data loads even when not valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      extdimmt4_r <= '0;
      target_r    <= '0;
      out_valid_r <= 1'b0;
    end else if (bus.flush) begin
      extdimmt4_r <= '0;
      target_r    <= '0;
      out_valid_r <= 1'b0;
    end else if (bus.stall) begin
      extdimmt4_r <= extdimmt4_r;
      target_r    <= target_r;
      out_valid_r <= out_valid_r;
    end else begin
      extdimmt4_r <= extdimmt4_s;
      target_r    <= target_sum_s;
      out_valid_r <= bus.in_valid;
    end
  end

  assign bus.extdimmt4   = extdimmt4_s;
  assign bus.shift_ovf   = shift_ovf_s;
  assign bus.extdimmt4_q = extdimmt4_r;
  assign bus.target_q    = target_r;
  assign bus.out_valid   = out_valid_r;

endmodule

// File: tb/tb_shift_left2.sv
// Scoreboard bench for shift_left2: the driver pushes expected outputs per
// cycle from an arithmetic reference; a negedge monitor pops and compares.
module tb_shift_left2;

  typedef struct {
    logic [31:0] t4;
    logic        ovf;
    logic [31:0] q4;
    logic [31:0] tgt;
    logic        vld;
    string       tag;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  exp_t sb_q[$];

  // Reference pipeline-register contents (what the registers hold now).
  logic [31:0] m_q4;
  logic [31:0] m_tgt;
  logic        m_vld;

  shift_left2_if #(.WIDTH(32)) bus ();

  shift_left2 #(.WIDTH(32), .SHIFT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One pipeline cycle: drive inputs, push expectation, advance the reference.
  task automatic step(input logic r, input logic f, input logic s, input logic v,
                      input logic [31:0] pc, input logic [31:0] imm, input string tag);
    exp_t        e;
    logic [31:0] prod;
    @(posedge clk);
    #1;
    reset        = r;
    bus.flush    = f;
    bus.stall    = s;
    bus.in_valid = v;
    bus.pc_plus4 = pc;
    bus.extdimm  = imm;
    prod  = imm * 32'd4;
    e.t4  = prod;
    e.ovf = ((longint'($signed(imm)) * 64'sd4) != longint'($signed(prod)));
    e.q4  = m_q4;
    e.tgt = m_tgt;
    e.vld = m_vld;
    e.tag = tag;
    sb_q.push_back(e);
    if (r || f) begin
      m_q4  = 32'd0;
      m_tgt = 32'd0;
      m_vld = 1'b0;
    end else if (!s) begin
      m_q4  = prod;
      m_tgt = pc + prod;
      m_vld = v;
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.tag, ".t4"},  bus.extdimmt4,          e.t4);
        chk({e.tag, ".ovf"}, {31'd0, bus.shift_ovf}, {31'd0, e.ovf});
        chk({e.tag, ".q4"},  bus.extdimmt4_q,        e.q4);
        chk({e.tag, ".tgt"}, bus.target_q,           e.tgt);
        chk({e.tag, ".vld"}, {31'd0, bus.out_valid}, {31'd0, e.vld});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] h;
    logic [31:0] imm;
    errors = 0;
    checks = 0;
    m_q4   = 32'd0;
    m_tgt  = 32'd0;
    m_vld  = 1'b0;
    reset        = 1'b1;
    bus.flush    = 1'b0;
    bus.stall    = 1'b0;
    bus.in_valid = 1'b0;
    bus.pc_plus4 = 32'd0;
    bus.extdimm  = 32'd0;

    // Combinational scaling vectors.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd3, "rst_x3");
    #1;
    chk("plan_x3", bus.extdimmt4, 32'h0000000C);
    chk("plan_x3_ovf", {31'd0, bus.shift_ovf}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'hFFFFFFFF, "neg1");
    #1;
    chk("plan_neg1", bus.extdimmt4, 32'hFFFFFFFC);
    chk("plan_neg1_ovf", {31'd0, bus.shift_ovf}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h40000000, "ovf");
    #1;
    chk("plan_ovf", bus.extdimmt4, 32'h00000000);
    chk("plan_ovf_flag", {31'd0, bus.shift_ovf}, 32'd1);

    // Reset, load and wrap-around.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "rst");
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h00400004, 32'd3, "load");
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000004, 32'hFFFFFFFE, "wrap1");
    #1;
    chk("plan_load_tgt", bus.target_q, 32'h00400010);
    chk("plan_load_q4", bus.extdimmt4_q, 32'h0000000C);
    chk("plan_load_vld", {31'd0, bus.out_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'd2, "wrap2");
    #1;
    chk("plan_wrap1", bus.target_q, 32'hFFFFFFFC);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h00001000, 32'd5, "pre_stall");
    #1;
    chk("plan_wrap2", bus.target_q, 32'h00000004);

    // Stall for three edges with changing inputs, then flush over stall.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, $urandom, $urandom, "stall");
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h00002000, 32'd7, "flush_stall");
    #1;
    chk("plan_stall_hold", bus.target_q, 32'h00001014);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h00000100, 32'd1, "novalid");
    #1;
    chk("plan_flush_tgt", bus.target_q, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000200, 32'd2, "reload");
    #1;
    chk("plan_novalid_vld", {31'd0, bus.out_valid}, 32'd0);
    chk("plan_novalid_tgt", bus.target_q, 32'h00000104);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h00000300, 32'd3, "rst_stall");
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h00000400, 32'd4, "after_rst");
    #1;
    chk("plan_rst_stall_vld", {31'd0, bus.out_valid}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      h = 16'($urandom);
      if ($urandom_range(0, 3) == 0) imm = $urandom;
      else imm = {{16{h[15]}}, h};
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) < 7),
           $urandom, imm, "rand");
    end

    @(posedge clk);
    for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drain", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
